sadd_operand_ser: RTL and testbench

Upstream operand serializer for the bit-serial adder. Accepts two parallel W-bit operands through a valid/ready handshake. Emits them LSB-first as 2-bit pairs x = {a_bit, b_bit}, one pair per clock, directly onto the adder's x input. Each word is closed with a flush pair 2'b00. On that cycle the adder outputs the carry-out bit and its carry state returns to clear, so consecutive words never leak carry.

---
 rtl/sadd_operand_ser.sv | 112 +++++++++++
 tb/tb_sadd_operand_ser.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sadd_operand_ser.sv
`default_nettype none
// ============================================================================
//  Module      : sadd_operand_ser
//  Description : LSB-first operand serializer feeding the bit-serial adder;
//                each word ends with a 2'b00 flush pair that yields carry-out.
//                Optional macro SADD_SER_SUB_EN adds a subtract mode (sub/x_prime).
//  Revision    : 1.0 - initial release
// ============================================================================
module sadd_operand_ser #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
`ifdef SADD_SER_SUB_EN
  input  logic         sub,
  output logic         x_prime,
`endif
  output logic [1:0]   x,
  output logic         x_valid,
  output logic         x_first,
  output logic         x_last
);

  localparam int            C_CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FLUSH = 2'd2,
    S_PRIME = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  state_t          w_start;
  logic [W-1:0]    r_sa;
  logic [W-1:0]    r_sb;
  logic [C_CW-1:0] r_cnt;
  logic            w_xfer;
  logic            w_sub;
  logic [W-1:0]    w_b_load;

`ifdef SADD_SER_SUB_EN
  assign w_sub   = sub;
  assign x_prime = (r_state == S_PRIME);
`else
  assign w_sub   = 1'b0;
`endif

  assign in_ready = (r_state == S_IDLE) || (r_state == S_FLUSH);
  assign w_xfer   = in_valid && in_ready;
  // Subtraction is A + ~B + 1: B is stored inverted, PRIME supplies the +1.
  assign w_b_load = w_sub ? ~op_b : op_b;
  assign w_start  = w_sub ? S_PRIME : S_SHIFT;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_xfer) begin
        r_sa  <= op_a;
        r_sb  <= w_b_load;
        r_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
        r_sa  <= r_sa >> 1;
        r_sb  <= r_sb >> 1;
        r_cnt <= r_cnt + C_CW'(1);
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    x       = 2'b00;
    x_valid = 1'b0;
    x_first = 1'b0;
    x_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) w_next = w_start;
      end
      S_SHIFT: begin
        x       = {r_sa[0], r_sb[0]};
        x_valid = 1'b1;
        x_first = (r_cnt == '0);
        if (r_cnt == C_LAST) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        x_valid = 1'b1;
        x_last  = 1'b1;
        w_next  = w_xfer ? w_start : S_IDLE;
      end
      S_PRIME: begin
        x       = 2'b11;
        x_valid = 1'b1;
        w_next  = S_SHIFT;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sadd_operand_ser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sadd_operand_ser
//  Description : Randomized and directed bench with a word-level stream model
//                and a bit-serial adder model checking sums.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sadd_operand_ser;

  localparam int W = 8;

  typedef struct packed {
    logic       v;
    logic [1:0] x;
    logic       f;
    logic       l;
    logic       p;
  } ent_t;

  logic         clk;
  logic         rst_b;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         tb_sub;
  logic [1:0]   x;
  logic         x_valid;
  logic         x_first;
  logic         x_last;
`ifdef SADD_SER_SUB_EN
  logic         x_prime;
`endif

  sadd_operand_ser #(.W(W)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
`ifdef SADD_SER_SUB_EN
    .sub      (tb_sub),
    .x_prime  (x_prime),
`endif
    .x        (x),
    .x_valid  (x_valid),
    .x_first  (x_first),
    .x_last   (x_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t       exp_q[$];
  logic [W:0] sum_q[$];
  int         n_chk;
  int         n_pass;
  logic       carry;
  logic [W:0] acc;
  int         idx;
  logic       exp_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
  endtask

  function automatic ent_t mk(input logic v, input logic [1:0] xx, input logic f,
                              input logic l, input logic p);
    ent_t e;
    e.v = v; e.x = xx; e.f = f; e.l = l; e.p = p;
    return e;
  endfunction

  task automatic push_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] bb;
    bb = s ? ~b : b;
    if (s) exp_q.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < W; i++)
      exp_q.push_back(mk(1'b1, {a[i], bb[i]}, (i == 0), 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 2'b00, 1'b0, 1'b1, 1'b0));
    sum_q.push_back((W+1)'(a) + (W+1)'(bb) + (W+1)'(s));
  endtask

  task automatic check_cycle();
    ent_t e;
    logic s;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    exp_rdy = !e.v || e.l;
    chk("x_valid",  32'(x_valid),  32'(e.v));
    chk("x",        32'(x),        32'(e.x));
    chk("x_first",  32'(x_first),  32'(e.f));
    chk("x_last",   32'(x_last),   32'(e.l));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
`ifdef SADD_SER_SUB_EN
    chk("x_prime",  32'(x_prime),  32'(e.p));
`endif
    // Bit-serial adder driven by the observed pairs.
    s = x[1] ^ x[0] ^ carry;
    if (x_valid && x_first) begin
      acc = '0;
      idx = 0;
    end
    if (x_valid && !x_last && !e.p && idx < W) begin
      acc[idx] = s;
      idx++;
    end
    if (x_valid && x_last) begin
      acc[W] = s;
      if (sum_q.size() > 0) chk("sum", 32'(acc), 32'(sum_q.pop_front()));
      else chk("sum_unexpected", 32'(acc), 32'hDEAD);
    end
    carry = (x[1] & x[0]) | (x[1] & carry) | (x[0] & carry);
  endtask

  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, output logic accepted);
    logic sv;
`ifdef SADD_SER_SUB_EN
    sv = s;
`else
    sv = 1'b0 & s;
`endif
    @(negedge clk);
    check_cycle();
    in_valid = v;
    op_a     = a;
    op_b     = b;
    tb_sub   = sv;
    accepted = v && exp_rdy;
    if (accepted) push_word(a, b, sv);
  endtask

  task automatic idle(input int n);
    logic acc_d;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, acc_d);
  endtask

  initial begin
    logic ok;
    int   tries;
    n_chk = 0; n_pass = 0; carry = 1'b0; acc = '0; idx = 0; exp_rdy = 1'b1;
    rst_b = 1'b0; in_valid = 1'b1; op_a = 8'hAA; op_b = 8'h55; tb_sub = 1'b0;

    // Reset held with in_valid high: no transfer, reset outputs.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_x",       32'(x),        32'd0);
    chk("rst_x_valid", 32'(x_valid),  32'd0);
    chk("rst_x_first", 32'(x_first),  32'd0);
    chk("rst_x_last",  32'(x_last),   32'd0);
    chk("rst_ready",   32'(in_ready), 32'd1);
    in_valid = 1'b0;
    rst_b    = 1'b1;
    idle(2);

    // Directed words.
    step(1'b1, 8'h05, 8'h03, 1'b0, ok); chk("acc_05_03", 32'(ok), 32'd1);
    idle(W + 2);
    step(1'b1, 8'hFF, 8'h01, 1'b0, ok); chk("acc_ff_01", 32'(ok), 32'd1);
    idle(W + 2);

    // Back-to-back: second word taken on the flush edge.
    step(1'b1, 8'h01, 8'h01, 1'b0, ok);
    tries = 0;
    do begin
      step(1'b1, 8'h02, 8'h02, 1'b0, ok);
      tries++;
    end while (!ok && tries < 50);
    chk("b2b_accept", 32'(ok), 32'd1);
    chk("b2b_cycles", 32'(tries), 32'(W + 1));
    idle(W + 3);

    // Reset pulse during the 4th shift cycle.
    step(1'b1, 8'h5A, 8'h3C, 1'b0, ok);
    idle(3);
    @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("mid_rst_x",       32'(x),        32'd0);
    chk("mid_rst_x_valid", 32'(x_valid),  32'd0);
    chk("mid_rst_x_last",  32'(x_last),   32'd0);
    chk("mid_rst_ready",   32'(in_ready), 32'd1);
    exp_q.delete();
    sum_q.delete();
    carry = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    step(1'b1, 8'h03, 8'h01, 1'b0, ok); chk("acc_03_01", 32'(ok), 32'd1);
    idle(W + 2);

`ifdef SADD_SER_SUB_EN
    step(1'b1, 8'h05, 8'h03, 1'b1, ok); chk("acc_sub", 32'(ok), 32'd1);
    idle(W + 3);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), W'($urandom), W'($urandom),
           $urandom_range(0, 1) == 1, ok);
    end
    in_valid = 1'b0;
    idle(W + 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
